// File: rtl/host_mem_loader.sv
// Host byte-stream loader: parses WRITE/START/CLR_ERR command packets and
// writes little-endian assembled words into the TPU unified memory.
module host_mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  tpu_start,
    input  logic                  tpu_busy,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_WORD - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GET_ADDR = 2'd1;
    localparam logic [1:0] GET_LEN  = 2'd2;
    localparam logic [1:0] DATA     = 2'd3;

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_START   = 8'h02;
    localparam logic [7:0] CMD_CLR_ERR = 8'h03;

    logic [1:0]            state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  tpu_start_q, tpu_start_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  accept;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tpu_start_d = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        addr_d      = addr_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    case (in_data)
                        CMD_WRITE:   state_d = GET_ADDR;
                        CMD_START:   tpu_start_d = 1'b1;
                        CMD_CLR_ERR: err_d = 1'b0;
                        default:     err_d = 1'b1;
                    endcase
                end
                GET_ADDR: begin
                    addr_d  = in_data[ADDR_WIDTH-1:0];
                    state_d = GET_LEN;
                end
                GET_LEN: begin
                    len_d      = in_data;
                    byte_cnt_d = '0;
                    if (in_data == 8'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
                default: begin
                    word_d[8*byte_cnt_q +: 8] = in_data;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d  = '0;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = word_d;
                        mem_addr_d  = addr_q;
                        addr_d      = addr_q + 1'b1;
                        len_d       = len_q - 1'b1;
                        if (len_q == 8'd1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            endcase
        end

        // Command acceptance is gated by tpu_busy only at the IDLE boundary.
        in_ready_d = !((state_d == IDLE) && tpu_busy);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tpu_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tpu_start_q <= tpu_start_d;
            done_q      <= done_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign tpu_start = tpu_start_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_host_mem_loader.sv
// Scoreboard bench for host_mem_loader: expected write/done/start events are
// queued by the stimulus and consumed by an independent output monitor.
module tb_host_mem_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        tpu_start;
    logic        tpu_busy;
    logic        busy;
    logic        done;
    logic        err;

    host_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .tpu_start(tpu_start), .tpu_busy(tpu_busy),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic        we;
        logic        dn;
        logic        st;
        logic [5:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic ev_t wr(input logic [5:0] a, input logic [31:0] d, input logic dn);
        ev_t e;
        e.we = 1'b1; e.dn = dn; e.st = 1'b0; e.addr = a; e.data = d;
        return e;
    endfunction

    function automatic ev_t flag(input logic dn, input logic st);
        ev_t e;
        e.we = 1'b0; e.dn = dn; e.st = st; e.addr = '0; e.data = '0;
        return e;
    endfunction

    // Monitor: every cycle with an output event consumes one expected entry.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (mem_we || done || tpu_start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {61'd0, mem_we, done, tpu_start}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_flags", {61'd0, mem_we, done, tpu_start}, {61'd0, e.we, e.dn, e.st});
                    if (e.we) begin
                        chk("mem_addr", {58'd0, mem_addr}, {58'd0, e.addr});
                        chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.data});
                    end
                end
            end
        end
    end

    // Drive one byte starting at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 64'd1, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_outs"}, {60'd0, mem_we, tpu_start, done, busy}, 64'd0);
        chk({tag, "_addr_data"}, {26'd0, mem_addr, mem_wdata}, 64'd0);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tpu_busy = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

        // Basic two-word write
        exp_q.push_back(wr(6'd5, 32'h12345678, 1'b0));
        exp_q.push_back(wr(6'd6, 32'hDEADBEEF, 1'b1));
        send(8'h01, 0); send(8'h05, 0); send(8'h02, 0);
        chk("busy_in_packet", {63'd0, busy}, 64'd1);
        send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0);
        chk("latency_we", {63'd0, mem_we}, 64'd1);
        send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
        @(negedge clk);
        chk("busy_after", {63'd0, busy}, 64'd0);

        // Address wrap 63 -> 0 -> 1
        exp_q.push_back(wr(6'd63, 32'h44332211, 1'b0));
        exp_q.push_back(wr(6'd0,  32'h88776655, 1'b0));
        exp_q.push_back(wr(6'd1,  32'hCCBBAA99, 1'b1));
        send(8'h01, 0); send(8'h3F, 0); send(8'h03, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
        send(8'h99, 0); send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);

        // Zero-length write: done only
        exp_q.push_back(flag(1'b1, 1'b0));
        send(8'h01, 0); send(8'h10, 0); send(8'h00, 0);
        @(negedge clk);
        chk("busy_len0", {63'd0, busy}, 64'd0);

        // Bad command, write while err set, then clear
        send(8'h7A, 0);
        chk("err_set", {63'd0, err}, 64'd1);
        exp_q.push_back(wr(6'd0, 32'hDDCCBBAA, 1'b1));
        send(8'h01, 0); send(8'h00, 0); send(8'h01, 0);
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
        chk("err_sticky", {63'd0, err}, 64'd1);
        send(8'h03, 0);
        chk("err_clear", {63'd0, err}, 64'd0);

        // START pulse, then blocking by tpu_busy
        exp_q.push_back(flag(1'b0, 1'b1));
        send(8'h02, 0);
        repeat (2) @(negedge clk);
        tpu_busy = 1'b1;
        @(negedge clk);
        chk("ready_blocked", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1;
        in_data  = 8'h02;
        repeat (5) @(negedge clk);
        chk("still_blocked", {63'd0, in_ready}, 64'd0);
        exp_q.push_back(flag(1'b0, 1'b1));
        tpu_busy = 1'b0;
        send(8'h02, 0);
        repeat (2) @(negedge clk);
        chk("start_drained", exp_q.size(), 64'd0);

        // Four-word write with random valid gaps
        for (int w = 0; w < 4; w++)
            exp_q.push_back(wr(6'(32 + w),
                {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, (w == 3)));
        send(8'h01, $urandom_range(0, 3));
        send(8'h20, $urandom_range(0, 3));
        send(8'h04, $urandom_range(0, 3));
        for (int i = 0; i < 16; i++) send(8'(i), $urandom_range(0, 3));

        // Reset mid-word: partial word dropped, outputs clear asynchronously
        send(8'h01, 0); send(8'h08, 0); send(8'h01, 0);
        send(8'h55, 0); send(8'h66, 0);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.push_back(wr(6'd9, 32'h04030201, 1'b1));
        send(8'h01, 0); send(8'h09, 0); send(8'h01, 0);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/host_mem_loader.md
Name: host_mem_loader

Overview:
- Host-side writer into the TPU's 64 x 32-bit unified memory.
- Accepts a byte stream from the host over a valid/ready interface and parses it into command packets.
- Assembles little-endian 32-bit words and issues single-cycle writes on the unified-memory write port.
- A separate command pulses the TPU start; no memory writes are accepted while the TPU is busy.

Parameters:
- DATA_WIDTH, 32, unified-memory word width; must be a multiple of 8.
- ADDR_WIDTH, 6, unified-memory address width (64 words).
- BYTES_PER_WORD, DATA_WIDTH/8, derived; not overridable.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  host byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at a rising edge.
- mem_we  out  1  one-cycle write strobe to unified memory.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  DATA_WIDTH  write data.
- tpu_start  out  1  one-cycle start pulse to the TPU.
- tpu_busy  in  1  TPU is computing.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a WRITE packet completes.
- err  out  1  sticky bad-command flag; cleared only by reset or by a CLR_ERR command.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, tpu_start=0, done=0, err=0, busy=0. All counters are cleared.
- in_ready is registered: it is 1 in every state after reset, except that it is 0 in IDLE while tpu_busy=1. It is recomputed every cycle.
- Packet format, byte 0 = command:
  - 0x01 WRITE: followed by a base address byte (low ADDR_WIDTH bits used, upper bits ignored), a length byte N (words, 0..255), then N*4 data bytes, least significant byte first.
  - 0x02 START: tpu_start pulses high for exactly 1 cycle, in the cycle after the command byte is accepted. State stays IDLE.
  - 0x03 CLR_ERR: err goes to 0 in the next cycle.
  - Any other value: err goes to 1 and the byte is discarded. State stays IDLE.
- FSM:
  - IDLE -> GET_ADDR on accepting 0x01.
  - GET_ADDR -> GET_LEN on the next accepted byte.
  - GET_LEN -> DATA if N>0. If N=0, go to IDLE with done pulsed the next cycle and no write.
  - DATA: a byte counter 0..3 shifts each accepted byte into word lane [8*k +: 8].
    - On accepting byte 3: the next cycle has mem_we=1, mem_wdata = assembled word, mem_addr = current address. The address then increments modulo 2^ADDR_WIDTH (wraps 63 -> 0), and the word counter decrements.
    - After the last word is accepted: -> IDLE. done pulses in the same cycle as the final mem_we.
- Latency: mem_we is asserted exactly 1 cycle after acceptance of the 4th byte of a word. Back-to-back bytes sustain one word every 4 cycles.
- mem_we is high for exactly 1 cycle per word. mem_addr and mem_wdata hold their values between writes.
- tpu_busy rising mid-packet does not stall the current packet; blocking applies only at the IDLE command boundary.
- in_valid deasserted mid-packet: the FSM holds state and all partial-word contents. There is no timeout.
- Reset asserted mid-packet: the partial word is dropped, no mem_we is issued, and all outputs take their reset values immediately.
- err does not abort anything except the offending byte; subsequent valid packets are processed normally.

Test Plan:
- Reset release, stream 01 05 02 | 78 56 34 12 | EF BE AD DE -> mem_we at addr 5 data 0x12345678, then addr 6 data 0xDEADBEEF. done is coincident with the second write; busy=0 afterwards.
- 01 3F 03 followed by 12 data bytes -> writes at addrs 63, 0, 1 (wrap-around).
- 01 10 00 -> no mem_we; done pulses once; FSM returns to IDLE.
- Byte 0x7A -> err=1 and no writes. Then 01 00 01 AA BB CC DD -> addr 0 data 0xDDCCBBAA while err stays 1. Then 03 -> err=0.
- Send 02 -> tpu_start high for exactly 1 cycle. Drive tpu_busy=1 -> in_ready=0 in IDLE and a pending byte is not consumed. Drop tpu_busy -> the byte is accepted.
- Random in_valid gaps inside a 4-word WRITE -> data is identical to the gap-free run. Reset asserted after 2 bytes of a word -> no mem_we; outputs are 0 asynchronously.
